branch_resolver: RTL and testbench
==================================

Name: branch_resolver

Overview:
- Resolution-side partner of the gshare predictor.
- Captures each ID-stage prediction (PHT index, predicted direction, PC) in a small in-order queue.
- Matches each entry against the actual outcome from EX and raises a one-cycle flush/redirect on mispredict.
- Drives the MEM-stage training interface (mem_q_is_branch, mem_q_jump_taken, mem_q_pht_idx) that updates the PHT and GHT.

Parameters:
- DEPTH, 4, in-flight branch entries held between ID and EX (power of two, ≥2).
- PHT_IDX_W, 6, width of the PHT index carried per entry.

Ports:
- clk_i  input  1  core clock
- rst_ni  input  1  asynchronous active-low reset
- id_push  input  1  branch leaving ID this cycle; capture an entry
- id_predict_btaken  input  1  predicted direction for the pushed branch
- id_pht_idx  input  PHT_IDX_W  PHT index used for the prediction
- id_pc  input  32  PC of the pushed branch
- ex_resolve  input  1  oldest in-flight branch resolved in EX this cycle
- ex_actual_taken  input  1  resolved direction
- ex_target  input  32  resolved taken target
- ext_flush  input  1  trap/exception flush; discards all entries
- id_stall  output  1  queue full; ID must hold its branch
- mem_q_is_branch  output  1  training valid
- mem_q_jump_taken  output  1  training direction
- mem_q_pht_idx  output  PHT_IDX_W  training index
- mispredict_flush  output  1  one-cycle pulse; flush IF/ID/EX
- redirect_pc  output  32  fetch target, valid with mispredict_flush
- err_overflow  output  1  sticky: push while full
- err_underflow  output  1  sticky: resolve while empty

Behaviour:
- Reset (async assert, sync deassert): queue empty; all outputs 0; redirect_pc = 0; sticky errors cleared.
- Queue:
  - Circular FIFO with read/write pointers and a count.
  - Push writes {pht_idx, predicted_taken, pc} at the tail.
  - Resolve pops the head.
  - Push and resolve in the same cycle with count in 1..DEPTH-1: both occur, count unchanged.
- id_stall = (count == DEPTH), combinational.
  - Push while full (and no same-cycle resolve): entry dropped, err_overflow set.
  - Push while full with a same-cycle resolve: accepted.
- Resolve with count == 0 and no same-cycle push: ignored, err_underflow set, no training.
- Resolve with count == 0 and a same-cycle push: counts as underflow; the push is captured normally.
- Comparison is made against the head entry: mispredict = ex_actual_taken != head.predicted_taken.
- Registered outputs, cycle after ex_resolve:
  - mem_q_is_branch = 1; mem_q_jump_taken = ex_actual_taken; mem_q_pht_idx = head.pht_idx.
  - mispredict_flush = mispredict.
  - redirect_pc = ex_actual_taken ? ex_target : head.pc + 32'd4 (mod 2^32).
  - All pulse outputs return to 0 the following cycle unless another resolve occurs. redirect_pc holds its last value.
- Mispredict squash:
  - In the resolve cycle, all entries younger than the head are discarded. Count becomes 0 and pointers are equalised.
  - A same-cycle id_push is also discarded, since it is wrong-path. It is not an overflow.
- ext_flush:
  - Clears the queue the same cycle; a same-cycle push is discarded.
  - A same-cycle resolve is still trained and may still pulse mispredict_flush.
  - ext_flush does not clear sticky errors.
- Back-to-back resolves every cycle are supported; training outputs are emitted every cycle.

Optional Feature:
- Macro: BRANCH_RESOLVER_STATS_EN.
- Defined:
  - Adds outputs stat_branches (32) and stat_mispredicts (32), counted on each valid resolve and each mispredict.
  - Counters saturate at 32'hFFFF_FFFF and reset to 0.
  - Adds input stat_clear (1), which zeroes both counters synchronously. stat_clear has priority over an increment in the same cycle.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Correct prediction: push {idx=6'h15, pred=1, pc=32'h100}, resolve taken, target 32'h200 -> next cycle mem_q_is_branch=1, taken=1, idx=6'h15, mispredict_flush=0.
- Mispredict NT→T: push {idx=6'h03, pred=0, pc=32'h40} plus two younger pushes; resolve taken, target 32'h80 -> flush=1, redirect_pc=32'h80, count=0, idx=6'h03 trained.
- Mispredict T→NT at wrap: pc=32'hFFFF_FFFC, pred=1, resolve not-taken -> redirect_pc=32'h0000_0000, flush=1.
- Full queue: DEPTH pushes -> id_stall=1; an extra push with no resolve -> err_overflow=1, FIFO contents unchanged; push and resolve together when full -> accepted, id_stall stays 1.
- Empty resolve and ext_flush: resolve with count=0 -> err_underflow=1, mem_q_is_branch=0; 3 pushes then ext_flush with a same-cycle push -> count=0, next resolve flags underflow.
- Async reset mid-stream: assert rst_ni low between clock edges with 2 entries queued and a pending pulse -> all outputs 0 immediately, count=0, errors cleared.

Source files
------------

// File: rtl/branch_resolver.sv
// In-order resolution queue for gshare branch predictions: matches EX outcomes to ID predictions,
// drives PHT/GHT training and mispredict redirect. Optional counters behind BRANCH_RESOLVER_STATS_EN.
module branch_resolver #(
  parameter int DEPTH     = 4,
  parameter int PHT_IDX_W = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
`ifdef BRANCH_RESOLVER_STATS_EN
  input  logic                 stat_clear,
  output logic [31:0]          stat_branches,
  output logic [31:0]          stat_mispredicts,
`endif
  input  logic                 id_push,
  input  logic                 id_predict_btaken,
  input  logic [PHT_IDX_W-1:0] id_pht_idx,
  input  logic [31:0]          id_pc,
  input  logic                 ex_resolve,
  input  logic                 ex_actual_taken,
  input  logic [31:0]          ex_target,
  input  logic                 ext_flush,
  output logic                 id_stall,
  output logic                 mem_q_is_branch,
  output logic                 mem_q_jump_taken,
  output logic [PHT_IDX_W-1:0] mem_q_pht_idx,
  output logic                 mispredict_flush,
  output logic [31:0]          redirect_pc,
  output logic                 err_overflow,
  output logic                 err_underflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    seq_pc = pc + 32'd4;
  endfunction

  logic [PHT_IDX_W-1:0] idx_mem  [DEPTH];
  logic                 pred_mem [DEPTH];
  logic [31:0]          pc_mem   [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic        full;
  logic        empty;
  logic        resolve_p0;
  logic        underflow_p0;
  logic        mispredict_p0;
  logic        squash_p0;
  logic        push_p0;
  logic        overflow_p0;
  logic [31:0] redirect_p0;

  // p0: resolve-cycle decode against the head entry
  always_comb begin
    full          = (count == FULL_CNT);
    empty         = (count == '0);
    resolve_p0    = ex_resolve && !empty;
    underflow_p0  = ex_resolve && empty;
    mispredict_p0 = resolve_p0 && (ex_actual_taken != pred_mem[rd_ptr]);
    // A mispredict or external flush makes any same-cycle push wrong-path.
    squash_p0     = mispredict_p0 || ext_flush;
    push_p0       = id_push && !squash_p0 && (!full || resolve_p0);
    overflow_p0   = id_push && !squash_p0 && full && !resolve_p0;
    redirect_p0   = ex_actual_taken ? ex_target : seq_pc(pc_mem[rd_ptr]);
  end

  assign id_stall = full;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (squash_p0) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push_p0)    wr_ptr <= wr_ptr + PTR_W'(1);
      if (resolve_p0) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_p0, resolve_p0})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_p0) begin
      idx_mem[wr_ptr]  <= id_pht_idx;
      pred_mem[wr_ptr] <= id_predict_btaken;
      pc_mem[wr_ptr]   <= id_pc;
    end
  end

  // p1: registered training / redirect outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q_is_branch  <= 1'b0;
      mem_q_jump_taken <= 1'b0;
      mem_q_pht_idx    <= '0;
      mispredict_flush <= 1'b0;
      redirect_pc      <= '0;
      err_overflow     <= 1'b0;
      err_underflow    <= 1'b0;
    end else begin
      mem_q_is_branch  <= resolve_p0;
      mem_q_jump_taken <= resolve_p0 && ex_actual_taken;
      mem_q_pht_idx    <= resolve_p0 ? idx_mem[rd_ptr] : '0;
      mispredict_flush <= mispredict_p0;
      if (resolve_p0) redirect_pc <= redirect_p0;
      err_overflow     <= err_overflow  | overflow_p0;
      err_underflow    <= err_underflow | underflow_p0;
    end
  end

`ifdef BRANCH_RESOLVER_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (stat_clear) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (resolve_p0 && (stat_branches != 32'hFFFF_FFFF))
        stat_branches <= stat_branches + 32'd1;
      if (mispredict_p0 && (stat_mispredicts != 32'hFFFF_FFFF))
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Table-driven directed bench for branch_resolver (DEPTH=4, PHT_IDX_W=6), plus an async-reset sequence.
module tb_branch_resolver;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        id_push, id_predict_btaken;
  logic [5:0]  id_pht_idx;
  logic [31:0] id_pc;
  logic        ex_resolve, ex_actual_taken;
  logic [31:0] ex_target;
  logic        ext_flush;
  logic        id_stall, mem_q_is_branch, mem_q_jump_taken;
  logic [5:0]  mem_q_pht_idx;
  logic        mispredict_flush;
  logic [31:0] redirect_pc;
  logic        err_overflow, err_underflow;

  int n_chk  = 0;
  int n_fail = 0;

  branch_resolver #(.DEPTH(4), .PHT_IDX_W(6)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .id_push(id_push), .id_predict_btaken(id_predict_btaken),
    .id_pht_idx(id_pht_idx), .id_pc(id_pc),
    .ex_resolve(ex_resolve), .ex_actual_taken(ex_actual_taken),
    .ex_target(ex_target), .ext_flush(ext_flush),
    .id_stall(id_stall), .mem_q_is_branch(mem_q_is_branch),
    .mem_q_jump_taken(mem_q_jump_taken), .mem_q_pht_idx(mem_q_pht_idx),
    .mispredict_flush(mispredict_flush), .redirect_pc(redirect_pc),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        push, pred;
    logic [5:0]  idx;
    logic [31:0] pc;
    logic        res, act;
    logic [31:0] tgt;
    logic        xfl;
    logic        stall, isb, jt;
    logic [5:0]  qidx;
    logic        mf;
    logic [31:0] rpc;
    logic        ovf, unf;
    int          cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic push, input logic pred, input logic [5:0] idx, input logic [31:0] pc,
    input logic res, input logic act, input logic [31:0] tgt, input logic xfl,
    input logic stall, input logic isb, input logic jt, input logic [5:0] qidx,
    input logic mf, input logic [31:0] rpc, input logic ovf, input logic unf, input int cnt);
    vec_t v;
    v.push = push; v.pred = pred; v.idx = idx; v.pc = pc;
    v.res = res; v.act = act; v.tgt = tgt; v.xfl = xfl;
    v.stall = stall; v.isb = isb; v.jt = jt; v.qidx = qidx;
    v.mf = mf; v.rpc = rpc; v.ovf = ovf; v.unf = unf; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_push = v.push; id_predict_btaken = v.pred; id_pht_idx = v.idx; id_pc = v.pc;
    ex_resolve = v.res; ex_actual_taken = v.act; ex_target = v.tgt; ext_flush = v.xfl;
  endtask

  task automatic check_state(input string tag, input vec_t v);
    chk({tag, " id_stall"},         32'(id_stall),         32'(v.stall));
    chk({tag, " mem_q_is_branch"},  32'(mem_q_is_branch),  32'(v.isb));
    chk({tag, " mem_q_jump_taken"}, 32'(mem_q_jump_taken), 32'(v.jt));
    chk({tag, " mem_q_pht_idx"},    32'(mem_q_pht_idx),    32'(v.qidx));
    chk({tag, " mispredict_flush"}, 32'(mispredict_flush), 32'(v.mf));
    chk({tag, " redirect_pc"},      redirect_pc,           v.rpc);
    chk({tag, " err_overflow"},     32'(err_overflow),     32'(v.ovf));
    chk({tag, " err_underflow"},    32'(err_underflow),    32'(v.unf));
    chk({tag, " count"},            32'(dut.count),        32'(v.cnt));
  endtask

  // Drive one cycle of inputs, then check registered state just after the edge.
  task automatic step(input string tag, input vec_t v);
    drive(v);
    @(posedge clk_i);
    #1;
    check_state(tag, v);
  endtask

  initial begin
    rst_ni = 1'b0;
    drive(mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,0,0));
    repeat (2) @(posedge clk_i);
    #1;
    check_state("reset", mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0,32'h0,0,0,0));
    @(negedge clk_i);
    rst_ni = 1'b1;

    //         push pred idx    pc            res act tgt           xfl  stall isb jt qidx  mf rpc           ovf unf cnt
    vecs.push_back(mk(1,1,6'h15,32'h100,       0,0,32'h0,        0,   0,0,0,6'h00,0,32'h0,       0,0,1));
    vecs.push_back(mk(0,0,6'h00,32'h0,         1,1,32'h200,      0,   0,1,1,6'h15,0,32'h200,     0,0,0));
    vecs.push_back(mk(0,0,6'h00,32'h0,         0,0,32'h0,        0,   0,0,0,6'h00,0,32'h200,     0,0,0));
    vecs.push_back(mk(1,0,6'h03,32'h40,        0,0,32'h0,        0,   0,0,0,6'h00,0,32'h200,     0,0,1));
    vecs.push_back(mk(1,1,6'h0A,32'h44,        0,0,32'h0,        0,   0,0,0,6'h00,0,32'h200,     0,0,2));
    vecs.push_back(mk(1,0,6'h0B,32'h48,        0,0,32'h0,        0,   0,0,0,6'h00,0,32'h200,     0,0,3));
    vecs.push_back(mk(1,1,6'h2A,32'h4C,        1,1,32'h80,       0,   0,1,1,6'h03,1,32'h80,      0,0,0));
    vecs.push_back(mk(0,0,6'h00,32'h0,         0,0,32'h0,        0,   0,0,0,6'h00,0,32'h80,      0,0,0));
    vecs.push_back(mk(1,1,6'h3F,32'hFFFF_FFFC, 0,0,32'h0,        0,   0,0,0,6'h00,0,32'h80,      0,0,1));
    vecs.push_back(mk(0,0,6'h00,32'h0,         1,0,32'h1234,     0,   0,1,0,6'h3F,1,32'h0,       0,0,0));
    vecs.push_back(mk(1,1,6'h01,32'h10,        0,0,32'h0,        0,   0,0,0,6'h00,0,32'h0,       0,0,1));
    vecs.push_back(mk(1,0,6'h02,32'h20,        0,0,32'h0,        0,   0,0,0,6'h00,0,32'h0,       0,0,2));
    vecs.push_back(mk(1,1,6'h04,32'h30,        0,0,32'h0,        0,   0,0,0,6'h00,0,32'h0,       0,0,3));
    vecs.push_back(mk(1,0,6'h08,32'h50,        0,0,32'h0,        0,   1,0,0,6'h00,0,32'h0,       0,0,4));
    vecs.push_back(mk(1,1,6'h11,32'h60,        0,0,32'h0,        0,   1,0,0,6'h00,0,32'h0,       1,0,4));
    vecs.push_back(mk(1,0,6'h12,32'h70,        1,1,32'h500,      0,   1,1,1,6'h01,0,32'h500,     1,0,4));
    vecs.push_back(mk(0,0,6'h00,32'h0,         1,0,32'h0,        0,   0,1,0,6'h02,0,32'h24,      1,0,3));
    vecs.push_back(mk(0,0,6'h00,32'h0,         1,1,32'h600,      0,   0,1,1,6'h04,0,32'h600,     1,0,2));
    vecs.push_back(mk(0,0,6'h00,32'h0,         1,0,32'h0,        0,   0,1,0,6'h08,0,32'h54,      1,0,1));
    vecs.push_back(mk(0,0,6'h00,32'h0,         1,0,32'h0,        0,   0,1,0,6'h12,0,32'h74,      1,0,0));
    vecs.push_back(mk(0,0,6'h00,32'h0,         1,1,32'h900,      0,   0,0,0,6'h00,0,32'h74,      1,1,0));
    vecs.push_back(mk(1,1,6'h05,32'h80,        0,0,32'h0,        0,   0,0,0,6'h00,0,32'h74,      1,1,1));
    vecs.push_back(mk(1,1,6'h06,32'h84,        0,0,32'h0,        0,   0,0,0,6'h00,0,32'h74,      1,1,2));
    vecs.push_back(mk(1,1,6'h07,32'h88,        0,0,32'h0,        0,   0,0,0,6'h00,0,32'h74,      1,1,3));
    vecs.push_back(mk(1,1,6'h09,32'h8C,        0,0,32'h0,        1,   0,0,0,6'h00,0,32'h74,      1,1,0));
    vecs.push_back(mk(0,0,6'h00,32'h0,         1,1,32'h0,        0,   0,0,0,6'h00,0,32'h74,      1,1,0));
    vecs.push_back(mk(1,0,6'h0C,32'h90,        0,0,32'h0,        0,   0,0,0,6'h00,0,32'h74,      1,1,1));
    vecs.push_back(mk(1,0,6'h0D,32'h94,        0,0,32'h0,        0,   0,0,0,6'h00,0,32'h74,      1,1,2));
    vecs.push_back(mk(0,0,6'h00,32'h0,         1,1,32'hA00,      1,   0,1,1,6'h0C,1,32'hA00,     1,1,0));
    vecs.push_back(mk(0,0,6'h00,32'h0,         0,0,32'h0,        0,   0,0,0,6'h00,0,32'hA00,     1,1,0));

    for (int i = 0; i < vecs.size(); i++)
      step($sformatf("row%0d", i), vecs[i]);

    // Async reset between edges with two entries queued and a training pulse pending.
    step("pre_rst_a", mk(1,1,6'h13,32'h100, 0,0,32'h0,   0, 0,0,0,6'h00,0,32'hA00,1,1,1));
    step("pre_rst_b", mk(1,0,6'h14,32'h104, 0,0,32'h0,   0, 0,0,0,6'h00,0,32'hA00,1,1,2));
    step("pre_rst_c", mk(1,1,6'h15,32'h108, 0,0,32'h0,   0, 0,0,0,6'h00,0,32'hA00,1,1,3));
    step("pre_rst_d", mk(0,0,6'h00,32'h0,   1,1,32'h300, 0, 0,1,1,6'h13,0,32'h300,1,1,2));
    drive(mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,0,0));
    #2;
    rst_ni = 1'b0;
    #1;
    check_state("async_rst", mk(0,0,0,0, 0,0,0,0, 0,0,0,6'h00,0,32'h0,0,0,0));
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Underflow with a same-cycle push: push still captured, then trained normally.
    step("unf_push", mk(1,0,6'h16,32'h200, 1,0,32'h0, 0, 0,0,0,6'h00,0,32'h0,  0,1,1));
    step("unf_res",  mk(0,0,6'h00,32'h0,   1,0,32'h0, 0, 0,1,0,6'h16,0,32'h204,0,1,0));
    step("unf_idle", mk(0,0,6'h00,32'h0,   0,0,32'h0, 0, 0,0,0,6'h00,0,32'h204,0,1,0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
